// File: rtl/alarm_zone_ctrl.sv
// alarm_zone_ctrl
//   Multi-zone Moore alarm controller. There are N sensor zones, plus arm and
//   disarm commands. Zones can use an entry-delay countdown or trip instantly.
//   Each zone's trip is latched in a sticky record. All outputs are registered
//   and update on the same edge as the state.
//
// Ports
//   clk         clock, all logic on posedge
//   resetn      synchronous reset, active low
//   arm         arm request (level)
//   disarm      disarm request (level)
//   zone_in     raw asynchronous sensor lines, 1 = zone violated
//   delay_mask  1 = zone uses entry delay, 0 = instant zone (static)
//   state       current state: 00 DIS, 01 ARM, 10 ENTRY, 11 ALARM
//   armed       1 in ARM, ENTRY, ALARM
//   warn        1 in ENTRY only
//   siren       1 in ALARM only
//   arm_err     one-cycle pulse when an arm request is refused
//   tripped     sticky record of zones violated while armed
//
// state | meaning
// ------+---------------------------------------------------------
// DIS   | disarmed, waiting for an arm request with all zones clear
// ARM   | armed and watching all zones
// ENTRY | delayed zone hit, entry countdown running
// ALARM | siren on until disarmed
module alarm_zone_ctrl #(
    parameter int N_ZONES   = 4,
    parameter int DLY_W     = 8,
    parameter int ENTRY_DLY = 20
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               arm,
    input  logic               disarm,
    input  logic [N_ZONES-1:0] zone_in,
    input  logic [N_ZONES-1:0] delay_mask,
    output logic [1:0]         state,
    output logic               armed,
    output logic               warn,
    output logic               siren,
    output logic               arm_err,
    output logic [N_ZONES-1:0] tripped
);

    typedef enum logic [1:0] {
        S_DIS   = 2'b00,
        S_ARM   = 2'b01,
        S_ENTRY = 2'b10,
        S_ALARM = 2'b11
    } state_t;

    // The counter holds "cycles left minus one", so ENTRY lasts ENTRY_DLY cycles.
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(ENTRY_DLY - 1);

    state_t             cur, nxt;
    logic [DLY_W-1:0]   cnt, cnt_nxt;
    logic [N_ZONES-1:0] sync1, zs;
    logic [N_ZONES-1:0] zi, zd;
    logic [N_ZONES-1:0] trip_nxt;
    logic               err_nxt;
    logic               armed_nxt, warn_nxt, siren_nxt;

    assign zi = zs & ~delay_mask;
    assign zd = zs & delay_mask;

    // State register, counter, synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur     <= S_DIS;
            cnt     <= '0;
            sync1   <= '0;
            zs      <= '0;
            tripped <= '0;
            armed   <= 1'b0;
            warn    <= 1'b0;
            siren   <= 1'b0;
            arm_err <= 1'b0;
        end else begin
            cur     <= nxt;
            cnt     <= cnt_nxt;
            sync1   <= zone_in;
            zs      <= sync1;
            tripped <= trip_nxt;
            armed   <= armed_nxt;
            warn    <= warn_nxt;
            siren   <= siren_nxt;
            arm_err <= err_nxt;
        end
    end

    // Next-state logic. Priority: disarm > instant/timeout > delayed > arm.
    always_comb begin
        nxt      = cur;
        cnt_nxt  = cnt;
        err_nxt  = 1'b0;
        trip_nxt = tripped | ((cur != S_DIS) ? zs : '0);
        case (cur)
            S_DIS: begin
                if (!disarm && arm) begin
                    if (zs == '0) begin
                        nxt      = S_ARM;
                        trip_nxt = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_ARM: begin
                if (disarm) begin
                    nxt = S_DIS;
                end else if (|zi) begin
                    nxt = S_ALARM;
                end else if (|zd) begin
                    nxt     = S_ENTRY;
                    cnt_nxt = DLY_LOAD;
                end
            end
            S_ENTRY: begin
                if (disarm) begin
                    nxt = S_DIS;
                end else if (|zi || cnt == '0) begin
                    nxt = S_ALARM;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_ALARM: begin
                if (disarm) begin
                    nxt = S_DIS;
                end
            end
            default: nxt = S_DIS;
        endcase
    end

    // Moore outputs are computed from the next state and registered with it.
    always_comb begin
        armed_nxt = (nxt != S_DIS);
        warn_nxt  = (nxt == S_ENTRY);
        siren_nxt = (nxt == S_ALARM);
    end

    assign state = cur;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Scoreboard bench for alarm_zone_ctrl. The driver applies inputs on the
// negative edge. A reference model then computes what the outputs must be
// after the next rising edge and queues that result. A monitor compares the
// DUT outputs against the queue shortly after each rising edge.
module tb_alarm_zone_ctrl;

    localparam int NZ  = 4;
    localparam int DLY = 5;

    logic          clk = 1'b0;
    logic          resetn, arm, disarm;
    logic [NZ-1:0] zone_in, delay_mask;
    logic [1:0]    state;
    logic          armed, warn, siren, arm_err;
    logic [NZ-1:0] tripped;

    alarm_zone_ctrl #(.N_ZONES(NZ), .DLY_W(8), .ENTRY_DLY(DLY)) dut (
        .clk(clk), .resetn(resetn), .arm(arm), .disarm(disarm),
        .zone_in(zone_in), .delay_mask(delay_mask), .state(state),
        .armed(armed), .warn(warn), .siren(siren), .arm_err(arm_err),
        .tripped(tripped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    st;
        logic          armed;
        logic          warn;
        logic          siren;
        logic          err;
        logic [NZ-1:0] trip;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   running = 1'b1;

    // Reference model. Modes are numbered by their debug code. The model keeps
    // the last two zone samples and the number of ENTRY cycles still to run.
    int            m_mode;
    int            m_left;
    logic [NZ-1:0] m_trip, m_hist0, m_hist1;
    logic          m_err;

    task automatic model_edge(input logic rn, input logic a, input logic d,
                              input logic [NZ-1:0] z);
        logic [NZ-1:0] seen, inst, dlyd;
        int nm;
        seen = m_hist1;
        inst = seen & ~delay_mask;
        dlyd = seen & delay_mask;
        m_err = 1'b0;
        if (!rn) begin
            m_mode = 0; m_left = 0; m_trip = '0; m_hist0 = '0; m_hist1 = '0;
            return;
        end
        if (m_mode != 0) m_trip = m_trip | seen;
        nm = m_mode;
        if (m_mode == 0) begin
            if (a && !d) begin
                if (seen == 0) begin nm = 1; m_trip = '0; end
                else m_err = 1'b1;
            end
        end else if (d) begin
            nm = 0;
        end else if (inst != 0) begin
            nm = 3;
        end else if (m_mode == 1 && dlyd != 0) begin
            nm = 2; m_left = DLY;
        end else if (m_mode == 2) begin
            if (m_left == 1) nm = 3;
            else m_left = m_left - 1;
        end
        m_mode  = nm;
        m_hist1 = m_hist0;
        m_hist0 = z;
    endtask

    task automatic step(input logic rn, input logic a, input logic d,
                        input logic [NZ-1:0] z);
        exp_t e;
        @(negedge clk);
        resetn = rn; arm = a; disarm = d; zone_in = z;
        model_edge(rn, a, d, z);
        e.st    = 2'(m_mode);
        e.armed = (m_mode != 0);
        e.warn  = (m_mode == 2);
        e.siren = (m_mode == 3);
        e.err   = m_err;
        e.trip  = m_trip;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0);
    endtask

    // Monitor
    always @(posedge clk) begin
        #1;
        if (running && sb.size() > 0) begin
            exp_t e, g;
            e = sb.pop_front();
            g = {state, armed, warn, siren, arm_err, tripped};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got st=%b armed=%b warn=%b siren=%b err=%b trip=%b exp st=%b armed=%b warn=%b siren=%b err=%b trip=%b",
                         $time, g.st, g.armed, g.warn, g.siren, g.err, g.trip,
                         e.st, e.armed, e.warn, e.siren, e.err, e.trip);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; arm = 1'b0; disarm = 1'b0; zone_in = '0;
        delay_mask = 4'b0001;
        m_mode = 0; m_left = 0; m_trip = '0; m_hist0 = '0; m_hist1 = '0; m_err = 1'b0;

        // Directed scenarios
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        idle(2);
        step(1'b1, 1'b1, 1'b0, '0);              // arm accepted
        idle(2);
        step(1'b1, 1'b0, 1'b0, 4'b0001);         // delayed zone pulse
        idle(12);                                // ENTRY for 5 cycles, then ALARM
        step(1'b0, 1'b0, 1'b0, '0);              // reset out of ALARM
        idle(2);
        step(1'b1, 1'b0, 1'b0, 4'b0100);
        step(1'b1, 1'b0, 1'b0, 4'b0100);
        step(1'b1, 1'b1, 1'b0, 4'b0100);         // arm refused
        idle(4);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 4'b0001);
        idle(3);                                 // first ENTRY cycle
        step(1'b1, 1'b0, 1'b1, '0);              // disarm on 2nd ENTRY cycle
        idle(3);
        step(1'b1, 1'b1, 1'b0, '0);              // rearm clears tripped
        idle(2);
        step(1'b1, 1'b0, 1'b0, 4'b0100);         // instant zone
        idle(5);
        step(1'b1, 1'b1, 1'b1, '0);              // arm and disarm together
        idle(2);
        step(1'b1, 1'b1, 1'b1, '0);              // arm and disarm in DIS
        idle(2);

        // Random phases with two delay masks
        for (int ph = 0; ph < 2; ph++) begin
            @(negedge clk);
            delay_mask = (ph == 0) ? 4'b0001 : 4'b1010;
            step(1'b0, 1'b0, 1'b0, '0);
            for (int i = 0; i < 1500; i++) begin
                logic rn, a, d;
                logic [NZ-1:0] z;
                rn = ($urandom_range(0, 299) != 0);
                a  = ($urandom_range(0, 3) == 0);
                d  = ($urandom_range(0, 24) == 0);
                z  = ($urandom_range(0, 7) == 0) ? NZ'($urandom) : '0;
                step(rn, a, d, z);
            end
        end
        idle(2);
        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
